// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - opcodes and FSM state encoding for regfile_ctrl
package regfile_ctrl_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ2 = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        RSP  = 2'b10,
        FILL = 2'b11
    } state_t;

endpackage

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - command-side initiator for a 2-read/1-write register file
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int BW_DATA = 16,
    parameter int BW_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_op,
    input  logic [BW_ADDR-1:0] i_cmd_addr0,
    input  logic [BW_ADDR-1:0] i_cmd_addr1,
    input  logic [BW_DATA-1:0] i_cmd_data,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [BW_DATA-1:0] o_rsp_data0,
    output logic [BW_DATA-1:0] o_rsp_data1,
    output logic               o_busy,
    output logic               o_rf_wr_en,
    output logic [BW_ADDR-1:0] o_rf_wr_addr,
    output logic [BW_DATA-1:0] o_rf_wr_data,
    output logic [BW_ADDR-1:0] o_rf_rd_addr0,
    output logic [BW_ADDR-1:0] o_rf_rd_addr1,
    input  logic [BW_DATA-1:0] i_rf_rd_data0,
    input  logic [BW_DATA-1:0] i_rf_rd_data1
);

    localparam logic [BW_ADDR-1:0] ADDR_LAST = '1;

    state_t state, state_next;
    logic   cmd_fire;

    assign o_cmd_ready = (state == IDLE);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    case (i_cmd_op)
                        OP_READ, OP_READ2: state_next = RD;
                        OP_FILL:           state_next = FILL;
                        default:           state_next = IDLE;
                    endcase
                end
            end
            RD:      state_next = RSP;
            RSP:     if (i_rsp_ready) state_next = IDLE;
            FILL:    if (o_rf_wr_addr == ADDR_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The write address doubles as the fill counter; the sweep stops on all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_rsp_valid   <= 1'b0;
            o_rsp_data0   <= '0;
            o_rsp_data1   <= '0;
            o_busy        <= 1'b0;
            o_rf_wr_en    <= 1'b0;
            o_rf_wr_addr  <= '0;
            o_rf_wr_data  <= '0;
            o_rf_rd_addr0 <= '0;
            o_rf_rd_addr1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_rf_wr_en <= 1'b0;
                    if (cmd_fire) begin
                        case (i_cmd_op)
                            OP_WRITE: begin
                                o_rf_wr_en   <= 1'b1;
                                o_rf_wr_addr <= i_cmd_addr0;
                                o_rf_wr_data <= i_cmd_data;
                            end
                            OP_READ: begin
                                o_rf_rd_addr0 <= i_cmd_addr0;
                                o_rf_rd_addr1 <= i_cmd_addr0;
                            end
                            OP_READ2: begin
                                o_rf_rd_addr0 <= i_cmd_addr0;
                                o_rf_rd_addr1 <= i_cmd_addr1;
                            end
                            default: begin
                                o_rf_wr_en   <= 1'b1;
                                o_rf_wr_addr <= '0;
                                o_rf_wr_data <= i_cmd_data;
                                o_busy       <= 1'b1;
                            end
                        endcase
                    end
                end
                RD: begin
                    o_rf_wr_en  <= 1'b0;
                    o_rsp_data0 <= i_rf_rd_data0;
                    o_rsp_data1 <= i_rf_rd_data1;
                    o_rsp_valid <= 1'b1;
                end
                RSP: begin
                    if (i_rsp_ready) o_rsp_valid <= 1'b0;
                end
                FILL: begin
                    if (o_rf_wr_addr == ADDR_LAST) begin
                        o_rf_wr_en <= 1'b0;
                        o_busy     <= 1'b0;
                    end else begin
                        o_rf_wr_addr <= o_rf_wr_addr + 1'b1;
                    end
                end
                default: o_rf_wr_en <= 1'b0;
            endcase
        end
    end

endmodule
